// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU; one op in flight at a time.
// Define ALU_ARB_RR_EN for round-robin tie-breaking, otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH_MAG = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [2**WIDTH_MAG-1:0]   req0_a,
    input  logic [2**WIDTH_MAG-1:0]   req0_b,
    input  logic                      req0_ic,
    input  logic [3:0]                req0_opcode,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [2**WIDTH_MAG-1:0]   req1_a,
    input  logic [2**WIDTH_MAG-1:0]   req1_b,
    input  logic                      req1_ic,
    input  logic [3:0]                req1_opcode,
    output logic [2**WIDTH_MAG-1:0]   alu_a,
    output logic [2**WIDTH_MAG-1:0]   alu_b,
    output logic                      alu_ic,
    output logic [3:0]                alu_opcode,
    input  logic [2**WIDTH_MAG-1:0]   alu_out,
    input  logic                      alu_oc,
    input  logic                      alu_oo,
    output logic                      resp0_valid,
    input  logic                      resp0_ready,
    output logic                      resp1_valid,
    input  logic                      resp1_ready,
    output logic [2**WIDTH_MAG-1:0]   resp_out,
    output logic                      resp_oc,
    output logic                      resp_oo,
    output logic [15:0]               op_count
);
    localparam int WIDTH = 2**WIDTH_MAG;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_reg;
    logic               owner_reg;
    logic               resp0_valid_reg;
    logic               resp1_valid_reg;
    logic [WIDTH-1:0]   resp_out_reg;
    logic               resp_oc_reg;
    logic               resp_oo_reg;
    logic [15:0]        op_count_reg;

    logic idle;
    logic grant1;
    logic accept;
    logic consume;

    assign idle = (state_reg == IDLE);

`ifdef ALU_ARB_RR_EN
    // Holds the port granted last; reset to 1 so port 0 wins the first tie.
    logic last_grant_reg;
    assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);
`else
    assign grant1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = idle && req0_valid && !grant1;
    assign req1_ready = idle && grant1;
    assign accept     = req0_ready || req1_ready;
    assign consume    = (state_reg == BUSY) && (owner_reg ? resp1_ready : resp0_ready);

    assign alu_a      = req1_ready ? req1_a      : (req0_ready ? req0_a      : '0);
    assign alu_b      = req1_ready ? req1_b      : (req0_ready ? req0_b      : '0);
    assign alu_ic     = req1_ready ? req1_ic     : (req0_ready ? req0_ic     : 1'b0);
    assign alu_opcode = req1_ready ? req1_opcode : (req0_ready ? req0_opcode : 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            owner_reg       <= 1'b0;
            resp0_valid_reg <= 1'b0;
            resp1_valid_reg <= 1'b0;
            resp_out_reg    <= '0;
            resp_oc_reg     <= 1'b0;
            resp_oo_reg     <= 1'b0;
            op_count_reg    <= 16'd0;
`ifdef ALU_ARB_RR_EN
            last_grant_reg  <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg       <= BUSY;
                        owner_reg       <= grant1;
                        resp0_valid_reg <= !grant1;
                        resp1_valid_reg <= grant1;
                        resp_out_reg    <= alu_out;
                        resp_oc_reg     <= alu_oc;
                        resp_oo_reg     <= alu_oo;
`ifdef ALU_ARB_RR_EN
                        last_grant_reg  <= grant1;
`endif
                    end
                end
                BUSY: begin
                    // Result regs are left untouched so they stay stable under backpressure.
                    if (consume) begin
                        state_reg       <= IDLE;
                        resp0_valid_reg <= 1'b0;
                        resp1_valid_reg <= 1'b0;
                        op_count_reg    <= op_count_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign resp0_valid = resp0_valid_reg;
    assign resp1_valid = resp1_valid_reg;
    assign resp_out    = resp_out_reg;
    assign resp_oc     = resp_oc_reg;
    assign resp_oo     = resp_oo_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared ALU port.
// Tie-break expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_arbiter;
    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_ic;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_opcode;
    logic        req1_valid, req1_ready, req1_ic;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_opcode;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_ic, alu_oc, alu_oo;
    logic [3:0]  alu_opcode;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_out;
    logic        resp_oc, resp_oo;
    logic [15:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.WIDTH_MAG(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ic(req0_ic), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ic(req1_ic), .req1_opcode(req1_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ic(alu_ic), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_oc(alu_oc), .alu_oo(alu_oo),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_out(resp_out), .resp_oc(resp_oc), .resp_oo(resp_oo),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcode 0 = ADD with carry, opcode 1 = XOR.
    logic [32:0] sum;
    always_comb begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ic};
        alu_out = 32'd0;
        alu_oc  = 1'b0;
        alu_oo  = 1'b0;
        case (alu_opcode)
            4'd0: begin
                alu_out = sum[31:0];
                alu_oc  = sum[32];
                alu_oo  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            4'd1: alu_out = alu_a ^ alu_b;
            default: alu_out = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic ic, input logic [3:0] op);
        if (port == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_ic = ic; req0_opcode = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_ic = ic; req1_opcode = op;
        end
    endtask

    task automatic clear_all();
        set_req(0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    // Single op on port 0: accept, then consume on the following cycle.
    task automatic op0(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        set_req(0, 1'b1, a, b, 1'b0, 4'd0);
        @(posedge clk); #1;
        req0_valid  = 1'b0;
        resp0_ready = 1'b1;
        @(posedge clk); #1;
        resp0_ready = 1'b0;
    endtask

    logic exp_g1;

    initial begin
        clear_all();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        check("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
        check("rst_resp_out", resp_out, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("idle_alu_a_zero", alu_a, 32'd0);

        // Tie: both valid, both consumers always ready.
        @(negedge clk);
        set_req(0, 1'b1, 32'd1, 32'd2, 1'b0, 4'd0);
        set_req(1, 1'b1, 32'd10, 32'd20, 1'b0, 4'd0);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ALU_ARB_RR_EN
            exp_g1 = (i % 2) == 1;
`else
            exp_g1 = 1'b0;
`endif
            check($sformatf("tie%0d_ready", i), {30'd0, req1_ready, req0_ready},
                  exp_g1 ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            check($sformatf("tie%0d_resp_out", i), resp_out, exp_g1 ? 32'd30 : 32'd3);
            check($sformatf("tie%0d_resp_valid", i), {30'd0, resp1_valid, resp0_valid},
                  exp_g1 ? 32'd2 : 32'd1);
            check($sformatf("tie%0d_busy_ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk);
        end
        #1;
        clear_all();
        check("tie_op_count", {16'd0, op_count}, 32'd4);

        // Single ADD on port 0 with carry out.
        @(negedge clk);
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0);
        #1;
        check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("single_alu_a", alu_a, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("single_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        check("single_resp_out", resp_out, 32'd0);
        check("single_oc_oo", {30'd0, resp_oc, resp_oo}, 32'd2);
        check("busy_alu_a_zero", alu_a, 32'd0);
        resp0_ready = 1'b1;
        @(posedge clk); #1;
        resp0_ready = 1'b0;
        check("single_consumed", {31'd0, resp0_valid}, 32'd0);
        check("single_op_count", {16'd0, op_count}, 32'd5);

        // Backpressure on port 1; port 0 pushes and asserts ready meanwhile.
        @(negedge clk);
        set_req(1, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 4'd1);
        #1;
        check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        set_req(0, 1'b1, 32'd7, 32'd7, 1'b0, 4'd0);
        resp0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_resp_out", i), resp_out, 32'h0000_FF00);
            check($sformatf("bp%0d_valid", i), {30'd0, resp1_valid, resp0_valid}, 32'd2);
            check($sformatf("bp%0d_req_ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req0_valid  = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b1;
        @(posedge clk); #1;
        resp1_ready = 1'b0;
        check("bp_done_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        check("bp_op_count", {16'd0, op_count}, 32'd6);

        // Reset while a port-0 response is pending.
        @(negedge clk);
        set_req(0, 1'b1, 32'd5, 32'd6, 1'b0, 4'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("mid_resp0_valid", {31'd0, resp0_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
        check("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        check("mid_rst_resp_out", resp_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_req(0, 1'b1, 32'd1, 32'd1, 1'b0, 4'd0);
        set_req(1, 1'b1, 32'd2, 32'd2, 1'b0, 4'd0);
        #1;
        check("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clk); #1;
        clear_all();
        resp0_ready = 1'b1;
        @(posedge clk); #1;
        resp0_ready = 1'b0;
        check("post_rst_op_count", {16'd0, op_count}, 32'd1);

        // Counter wrap: preload near the top instead of running 65535 operations.
        @(negedge clk);
        force dut.op_count_reg = 16'hFFFE;
        #1;
        release dut.op_count_reg;
        op0(32'd3, 32'd4);
        check("wrap_ffff", {16'd0, op_count}, 32'h0000_FFFF);
        op0(32'd3, 32'd4);
        check("wrap_zero", {16'd0, op_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL take parameter WIDTH_MAG, default 5, meaning operand width WIDTH = 2**WIDTH_MAG.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester n this cycle.
REQ-006 reqN_a, reqN_b  input  WIDTH  operands; reqN_ic  input  1  carry-in; reqN_opcode  input  4  ALU opcode.
REQ-007 alu_a, alu_b  output  WIDTH; alu_ic  output  1; alu_opcode  output  4  drive the shared ALU instance.
REQ-008 alu_out  input  WIDTH; alu_oc, alu_oo  input  1  combinational results from the shared ALU.
REQ-009 resp0_valid / resp1_valid  output  1  result available for requester n.
REQ-010 resp0_ready / resp1_ready  input  1  requester n consumes the result.
REQ-011 resp_out  output  WIDTH; resp_oc, resp_oo  output  1  registered result, shared by both response ports.
REQ-012 op_count  output  16  completed-operation counter.

Function
REQ-013 The block SHALL implement states IDLE and BUSY.
REQ-014 In IDLE, the grant SHALL go to the only valid requester; with both valid, the grant SHALL follow the REQ-027 policy.
REQ-015 In IDLE, reqN_ready SHALL be 1 only for the granted port, combinational from the valid inputs; both SHALL be 0 when no request is valid.
REQ-016 In IDLE, alu_a/alu_b/alu_ic/alu_opcode SHALL mux from the granted port; otherwise they SHALL be all-zero.
REQ-017 On accept (valid & ready), the block SHALL register alu_out/alu_oc/alu_oo into resp_out/resp_oc/resp_oo, record the owner, and enter BUSY.
REQ-018 Latency SHALL be one cycle: an operation accepted in cycle N gives respN_valid=1 in cycle N+1.
REQ-019 In BUSY, both req_ready SHALL be 0, and respN_valid SHALL be 1 only for the owner; the other resp_valid SHALL be 0.
REQ-020 resp_out/oc/oo SHALL remain stable while respN_valid=1 and respN_ready=0.
REQ-021 On respN_valid & respN_ready, the block SHALL return to IDLE and increment op_count; no new accept SHALL occur in that same cycle.
REQ-022 Maximum throughput SHALL be one operation per two cycles.
REQ-023 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-024 resp_ready on the non-owner port SHALL be ignored.
REQ-025 The block SHALL pass oc/oo through unmodified, including x values for non-add opcodes.
REQ-026 The block SHALL NOT validate opcode values.

Configuration
REQ-027 With macro ALU_ARB_RR_EN defined, a last-grant pointer SHALL select the port not granted most recently when both are valid; the pointer SHALL update on each accept.
REQ-028 Without ALU_ARB_RR_EN, port 0 SHALL always win when both are valid, and no pointer register SHALL exist.

Reset
REQ-029 On reset_n=0, the block SHALL immediately enter IDLE.
REQ-030 On reset_n=0, resp0_valid, resp1_valid, resp_out, resp_oc, resp_oo and op_count SHALL be 0.
REQ-031 On reset_n=0, the RR pointer SHALL be set so that port 0 wins the next tie.
REQ-032 A response pending at reset SHALL be discarded without incrementing op_count.
REQ-033 Outputs SHALL leave reset values only on a clk edge after reset_n rises.

Verification
REQ-034 Single op: req0 valid, ADD a=0xFFFFFFFF, b=1, ic=0 -> req0_ready=1, next cycle resp0_valid=1, resp_out=0, resp_oc=1, resp_oo=0; op_count=1 after consume.
REQ-035 Tie with RR: both valid every cycle, resp_ready=1 -> grants 0,1,0,1 on alternate cycles; without ALU_ARB_RR_EN -> grants 0,0,0.
REQ-036 Backpressure: req1 XOR 0xF0F0 ^ 0x0FF0, resp1_ready=0 for 5 cycles -> resp_out=0xFF00 held stable, both req_ready=0 throughout, completes on ready.
REQ-037 Reset mid-operation: accept on req0, assert reset_n=0 while resp0_valid=1 -> resp0_valid=0 and op_count=0 immediately; next tie grants port 0.
REQ-038 Counter wrap: preload by 65535 completions, then one more -> op_count=0x0000.
